// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch sequencing controller for the in-order RISC-V core. Every cycle it
// decides whether the program counter advances, holds or is redirected.
// It also drives the pipeline flush lines and the instruction-memory request.
//
// Redirect requests are ranked trap > EX branch > ID jump. A redirect that
// arrives while instruction memory is busy is parked in a pending register.
// It is applied on the next cycle in which memory returns a word.
// A fetch that stays not-ready for MEM_TIMEOUT cycles is abandoned, and
// the PC is sent to TRAP_VEC.
//
// Parameters
//   BOOT_ADDR    PC loaded in the first cycle after reset
//   TRAP_VEC     redirect target on fetch timeout
//   MEM_TIMEOUT  consecutive not-ready cycles that end a fetch (>= 2)
//
// Ports
//   clk              sole clock, rising edge
//   rst_sync         synchronous active-high reset
//   imem_ready       instruction memory returns the word for the current PC
//   load_use_hazard  ID instruction depends on the load in EX
//   br_taken_ex      EX branch/JALR resolved taken
//   br_target_ex     EX redirect target
//   jump_id          JAL decoded in ID
//   jump_target_id   JAL target
//   trap_req         trap/exception request
//   trap_addr        trap handler address
//   stall_n          to PC register: 1 = advance PC by 4
//   jump_en          to PC register: load jump_addr
//   jump_addr        redirect target
//   flush_ifid       squash the IF/ID register
//   flush_idex       squash the ID/EX register (insert bubble)
//   imem_req         fetch request for the current PC
//   fetch_fault      one-cycle pulse on fetch timeout
// ---------------------------------------------------------------------------
module fetch_ctrl #(
   parameter logic [31:0] BOOT_ADDR   = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC    = 32'h0000_0100,
   parameter int          MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_sync,
   input  logic        imem_ready,
   input  logic        load_use_hazard,
   input  logic        br_taken_ex,
   input  logic [31:0] br_target_ex,
   input  logic        jump_id,
   input  logic [31:0] jump_target_id,
   input  logic        trap_req,
   input  logic [31:0] trap_addr,
   output logic        stall_n,
   output logic        jump_en,
   output logic [31:0] jump_addr,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        imem_req,
   output logic        fetch_fault
);

   localparam int            CW      = $clog2(MEM_TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [1:0] {
      BOOT,
      RUN,
      FAULT
   } state_t;

   state_t        state;
   logic          pend_valid;
   logic [31:0]   pend_addr;
   logic          pend_trap;
   logic [CW-1:0] wait_cnt;

   logic          live_valid;
   logic [31:0]   live_addr;
   logic          live_jmp;
   logic          hard_redirect;
   logic          eff_load_use;
   logic          timeout;
   logic          may_park;

   // Live redirect arbitration. A trap or an EX redirect squashes both
   // younger stages. A JAL in ID only counts when no load-use stall is
   // holding the ID instruction in place.
   always_comb begin
      hard_redirect = trap_req | br_taken_ex;
      live_jmp      = jump_id & ~load_use_hazard & ~hard_redirect;
      live_valid    = hard_redirect | live_jmp;
      eff_load_use  = load_use_hazard & ~hard_redirect;
      live_addr     = jump_target_id;
      if (trap_req) begin
         live_addr = trap_addr;
      end else if (br_taken_ex) begin
         live_addr = br_target_ex;
      end
      timeout  = (state == RUN) && !imem_ready && (wait_cnt == CNT_MAX);
      // The newest redirect replaces the parked one. A parked trap can only
      // be replaced by another trap.
      may_park = live_valid && !(pend_valid && pend_trap && !trap_req);
   end

   // Output decode. Every output is combinational, so a live redirect reaches
   // jump_en in the same cycle that memory accepts the fetch.
   always_comb begin
      stall_n     = 1'b0;
      jump_en     = 1'b0;
      jump_addr   = 32'h0;
      flush_ifid  = 1'b0;
      flush_idex  = 1'b0;
      imem_req    = 1'b0;
      fetch_fault = 1'b0;
      if (rst_sync) begin
         flush_ifid = 1'b1;
         flush_idex = 1'b1;
      end else begin
         case (state)
            BOOT: begin
               jump_en    = 1'b1;
               jump_addr  = BOOT_ADDR;
               flush_ifid = 1'b1;
               flush_idex = 1'b1;
            end
            RUN: begin
               imem_req   = 1'b1;
               flush_ifid = hard_redirect | live_jmp;
               flush_idex = hard_redirect | eff_load_use;
               if (imem_ready) begin
                  if (live_valid) begin
                     jump_en   = 1'b1;
                     jump_addr = live_addr;
                  end else if (pend_valid) begin
                     // The word returned now was fetched from the wrong path.
                     jump_en    = 1'b1;
                     jump_addr  = pend_addr;
                     flush_ifid = 1'b1;
                  end
                  stall_n = ~jump_en & ~eff_load_use;
               end else if (timeout) begin
                  fetch_fault = 1'b1;
                  jump_en     = 1'b1;
                  jump_addr   = TRAP_VEC;
                  flush_ifid  = 1'b1;
                  flush_idex  = 1'b1;
               end
            end
            FAULT: begin
               // Abandoned fetch: every output stays at its idle value.
            end
            default: begin
            end
         endcase
      end
   end

   // State, pending redirect and memory-wait counter. A timeout or a reset
   // discards all parked work.
   always_ff @(posedge clk) begin
      if (rst_sync) begin
         state      <= BOOT;
         pend_valid <= 1'b0;
         pend_addr  <= 32'h0;
         pend_trap  <= 1'b0;
         wait_cnt   <= '0;
      end else begin
         case (state)
            BOOT: begin
               state      <= RUN;
               pend_valid <= 1'b0;
               wait_cnt   <= '0;
            end
            RUN: begin
               if (imem_ready) begin
                  pend_valid <= 1'b0;
                  wait_cnt   <= '0;
               end else if (timeout) begin
                  state      <= FAULT;
                  pend_valid <= 1'b0;
                  pend_trap  <= 1'b0;
                  wait_cnt   <= '0;
               end else begin
                  if (wait_cnt != CNT_MAX) begin
                     wait_cnt <= wait_cnt + 1'b1;
                  end
                  if (may_park) begin
                     pend_valid <= 1'b1;
                     pend_addr  <= live_addr;
                     pend_trap  <= trap_req;
                  end
               end
            end
            FAULT: begin
               state    <= RUN;
               wait_cnt <= '0;
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed self-checking bench for fetch_ctrl. Inputs change 1 ns after
// each rising edge. Outputs are sampled on the falling edge.
// The control outputs are checked as one packed vector, in this bit order:
//   {stall_n, jump_en, flush_ifid, flush_idex, imem_req, fetch_fault}
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

   logic        clk;
   logic        rst_sync;
   logic        imem_ready;
   logic        load_use_hazard;
   logic        br_taken_ex;
   logic [31:0] br_target_ex;
   logic        jump_id;
   logic [31:0] jump_target_id;
   logic        trap_req;
   logic [31:0] trap_addr;
   logic        stall_n;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        flush_ifid;
   logic        flush_idex;
   logic        imem_req;
   logic        fetch_fault;

   int tests_run;
   int tests_failed;

   logic [5:0] ctl;
   assign ctl = {stall_n, jump_en, flush_ifid, flush_idex, imem_req, fetch_fault};

   fetch_ctrl #(
      .BOOT_ADDR   (32'h0000_0000),
      .TRAP_VEC    (32'h0000_0100),
      .MEM_TIMEOUT (16)
   ) dut (
      .clk             (clk),
      .rst_sync        (rst_sync),
      .imem_ready      (imem_ready),
      .load_use_hazard (load_use_hazard),
      .br_taken_ex     (br_taken_ex),
      .br_target_ex    (br_target_ex),
      .jump_id         (jump_id),
      .jump_target_id  (jump_target_id),
      .trap_req        (trap_req),
      .trap_addr       (trap_addr),
      .stall_n         (stall_n),
      .jump_en         (jump_en),
      .jump_addr       (jump_addr),
      .flush_ifid      (flush_ifid),
      .flush_idex      (flush_idex),
      .imem_req        (imem_req),
      .fetch_fault     (fetch_fault)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard bound on total runtime
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      imem_ready      = 1'b1;
      load_use_hazard = 1'b0;
      br_taken_ex     = 1'b0;
      br_target_ex    = 32'h0;
      jump_id         = 1'b0;
      jump_target_id  = 32'h0;
      trap_req        = 1'b0;
      trap_addr       = 32'h0;
   endtask

   task automatic test_reset();
      // Reset must override active redirect inputs
      rst_sync     = 1'b1;
      trap_req     = 1'b1;
      trap_addr    = 32'h0000_0abc;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0def;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b001100) begin
         tests_failed++;
         $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, 6'b001100);
      end
      tests_run++;
      if (jump_addr !== 32'h0) begin
         tests_failed++;
         $display("[TB] FAIL reset_addr: got %h expected %h", jump_addr, 32'h0);
      end
      next_cycle();
      rst_sync = 1'b0;
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011100) begin
         tests_failed++;
         $display("[TB] FAIL boot_ctl: got %b expected %b", ctl, 6'b011100);
      end
      tests_run++;
      if (jump_addr !== 32'h0000_0000) begin
         tests_failed++;
         $display("[TB] FAIL boot_addr: got %h expected %h", jump_addr, 32'h0);
      end
      next_cycle();
   endtask

   task automatic test_idle();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (ctl !== 6'b100010) begin
            tests_failed++;
            $display("[TB] FAIL idle_%0d: got %b expected %b", i, ctl, 6'b100010);
         end
         next_cycle();
      end
   endtask

   task automatic test_priority();
      // EX branch beats ID jump
      br_taken_ex    = 1'b1;
      br_target_ex   = 32'h0000_0080;
      jump_id        = 1'b1;
      jump_target_id = 32'h0000_0040;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011110 || jump_addr !== 32'h0000_0080) begin
         tests_failed++;
         $display("[TB] FAIL br_vs_jump: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011110, 32'h80);
      end
      next_cycle();
      // Trap beats EX branch
      trap_req  = 1'b1;
      trap_addr = 32'h0000_0900;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011110 || jump_addr !== 32'h0000_0900) begin
         tests_failed++;
         $display("[TB] FAIL trap_vs_br: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011110, 32'h900);
      end
      next_cycle();
      // ID jump alone flushes only IF/ID
      clear_inputs();
      jump_id        = 1'b1;
      jump_target_id = 32'h0000_0040;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011010 || jump_addr !== 32'h0000_0040) begin
         tests_failed++;
         $display("[TB] FAIL jump_id: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011010, 32'h40);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_load_use();
      load_use_hazard = 1'b1;
      jump_id         = 1'b1;
      jump_target_id  = 32'h0000_0040;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b000110) begin
         tests_failed++;
         $display("[TB] FAIL load_use: got %b expected %b", ctl, 6'b000110);
      end
      next_cycle();
      // A branch in EX overrides the load-use bubble
      jump_id      = 1'b0;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0c00;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011110 || jump_addr !== 32'h0000_0c00) begin
         tests_failed++;
         $display("[TB] FAIL load_use_br: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011110, 32'hc00);
      end
      next_cycle();
      clear_inputs();
   endtask

   task automatic test_deferred();
      imem_ready   = 1'b0;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0200;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b001110) begin
         tests_failed++;
         $display("[TB] FAIL defer_arrive: got %b expected %b", ctl, 6'b001110);
      end
      next_cycle();
      br_taken_ex = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         tests_run++;
         if (ctl !== 6'b000010) begin
            tests_failed++;
            $display("[TB] FAIL defer_wait_%0d: got %b expected %b", i, ctl, 6'b000010);
         end
         next_cycle();
      end
      imem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011010 || jump_addr !== 32'h0000_0200) begin
         tests_failed++;
         $display("[TB] FAIL defer_apply: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011010, 32'h200);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b100010) begin
         tests_failed++;
         $display("[TB] FAIL defer_cleared: got %b expected %b", ctl, 6'b100010);
      end
      next_cycle();
   endtask

   task automatic test_pending_priority();
      // A parked trap survives a later EX branch
      imem_ready = 1'b0;
      trap_req   = 1'b1;
      trap_addr  = 32'h0000_0300;
      next_cycle();
      trap_req     = 1'b0;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0500;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b001110) begin
         tests_failed++;
         $display("[TB] FAIL pend_br_flush: got %b expected %b", ctl, 6'b001110);
      end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011010 || jump_addr !== 32'h0000_0300) begin
         tests_failed++;
         $display("[TB] FAIL pend_trap_kept: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011010, 32'h300);
      end
      next_cycle();
      // Between non-traps, the newest redirect wins
      imem_ready   = 1'b0;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0500;
      next_cycle();
      br_taken_ex    = 1'b0;
      jump_id        = 1'b1;
      jump_target_id = 32'h0000_0600;
      next_cycle();
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011010 || jump_addr !== 32'h0000_0600) begin
         tests_failed++;
         $display("[TB] FAIL pend_newest: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011010, 32'h600);
      end
      next_cycle();
   endtask

   task automatic test_counter_clear();
      // Two runs of 10 waits separated by an accept must not time out
      for (int r = 0; r < 2; r++) begin
         imem_ready = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests_run++;
            if (ctl !== 6'b000010) begin
               tests_failed++;
               $display("[TB] FAIL cnt_clear_%0d_%0d: got %b expected %b", r, i, ctl, 6'b000010);
            end
            next_cycle();
         end
         imem_ready = 1'b1;
         next_cycle();
      end
   endtask

   task automatic test_timeout();
      imem_ready = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         // A redirect parked early and a live trap on the last cycle are both discarded
         br_taken_ex  = (i == 2);
         br_target_ex = 32'h0000_0a00;
         trap_req     = (i == 16);
         trap_addr    = 32'h0000_0700;
         @(negedge clk);
         if (i < 16) begin
            if (i != 2) begin
               tests_run++;
               if (ctl !== 6'b000010) begin
                  tests_failed++;
                  $display("[TB] FAIL tmo_wait_%0d: got %b expected %b", i, ctl, 6'b000010);
               end
            end
         end else begin
            tests_run++;
            if (ctl !== 6'b011111 || jump_addr !== 32'h0000_0100) begin
               tests_failed++;
               $display("[TB] FAIL tmo_fire: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011111, 32'h100);
            end
         end
         next_cycle();
      end
      clear_inputs();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b000000) begin
         tests_failed++;
         $display("[TB] FAIL tmo_fault_state: got %b expected %b", ctl, 6'b000000);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b100010) begin
         tests_failed++;
         $display("[TB] FAIL tmo_resume: got %b expected %b", ctl, 6'b100010);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_wait();
      imem_ready   = 1'b0;
      br_taken_ex  = 1'b1;
      br_target_ex = 32'h0000_0b00;
      next_cycle();
      clear_inputs();
      imem_ready = 1'b0;
      rst_sync   = 1'b1;
      next_cycle();
      rst_sync   = 1'b0;
      imem_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b011100 || jump_addr !== 32'h0000_0000) begin
         tests_failed++;
         $display("[TB] FAIL rst_wait_boot: got %b/%h expected %b/%h", ctl, jump_addr, 6'b011100, 32'h0);
      end
      next_cycle();
      @(negedge clk);
      tests_run++;
      if (ctl !== 6'b100010) begin
         tests_failed++;
         $display("[TB] FAIL rst_wait_discard: got %b expected %b", ctl, 6'b100010);
      end
      next_cycle();
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_sync     = 1'b1;
      clear_inputs();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_idle();
      test_priority();
      test_load_use();
      test_deferred();
      test_pending_priority();
      test_counter_clear();
      test_timeout();
      test_reset_mid_wait();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
